// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned ITER_CNT = 32;
   localparam int unsigned CNT_W    = 6;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
   localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_QUOT     = 32'h8000_0000;
   localparam logic [31:0] OVF_REM      = 32'h0000_0000;

   // rs1 is signed for MUL/MULH/MULHSU/DIV/REM
   function automatic logic op_a_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is signed for MUL/MULH/DIV/REM
   function automatic logic op_b_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement of magnitude product, quotient and remainder.
module muldiv_sign_fix #(
   parameter int unsigned W = 32
) (
   input  logic [2*W-1:0] prod,
   input  logic           neg_prod,
   input  logic [W-1:0]   quot,
   input  logic           neg_quot,
   input  logic [W-1:0]   rem,
   input  logic           neg_rem,
   output logic [2*W-1:0] prod_fix,
   output logic [W-1:0]   quot_fix,
   output logic [W-1:0]   rem_fix
);

   assign prod_fix = neg_prod ? -prod : prod;
   assign quot_fix = neg_quot ? -quot : quot;
   assign rem_fix  = neg_rem  ? -rem  : rem;

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/done handshake.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplies.
module riscv_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Start,
   input  logic            Flush,
   input  logic [2:0]      Op,
   input  logic [XLEN-1:0] In_A,
   input  logic [XLEN-1:0] In_B,
   output logic            Ready,
   output logic            Busy,
   output logic            Done,
   output logic [XLEN-1:0] Result
);

   localparam int unsigned W  = XLEN;
   localparam int unsigned W2 = 2 * XLEN;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [W2-1:0]    p_q, p_nxt, p_step;
   logic [W-1:0]     m_q, m_nxt;
   logic [2:0]       op_q, op_nxt;
   logic             neg_lo_q, neg_lo_nxt, neg_rem_q, neg_rem_nxt;
   logic [W-1:0]     res_nxt;

   logic [W:0]       mul_sum, div_sh, div_diff;
   logic             a_neg, b_neg, div_zero, div_ovf;
   logic [W-1:0]     a_mag, b_mag, calc_res;
   logic [W2-1:0]    prod_fix;
   logic [W-1:0]     quot_fix, rem_fix;

   // One iteration: shift-add for multiply, restoring shift-subtract for divide
   always_comb begin
      mul_sum  = {1'b0, p_q[W2-1:W]} + (p_q[0] ? {1'b0, m_q} : (W+1)'(0));
      div_sh   = {p_q[W2-1:W], p_q[W-1]};
      div_diff = div_sh - {1'b0, m_q};
      if (!op_q[2])
         p_step = {mul_sum, p_q[W-1:1]};
      else if (!div_diff[W])
         p_step = {div_diff[W-1:0], p_q[W-2:0], 1'b1};
      else
         p_step = {div_sh[W-1:0], p_q[W-2:0], 1'b0};
   end

   muldiv_sign_fix #(.W(W)) u_sign_fix (
      .prod     (p_step),
      .neg_prod (neg_lo_q),
      .quot     (p_step[W-1:0]),
      .neg_quot (neg_lo_q),
      .rem      (p_step[W2-1:W]),
      .neg_rem  (neg_rem_q),
      .prod_fix (prod_fix),
      .quot_fix (quot_fix),
      .rem_fix  (rem_fix)
   );

   always_comb begin
      case (op_q)
         OP_MUL:                       calc_res = prod_fix[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[W2-1:W];
         OP_DIV, OP_DIVU:              calc_res = quot_fix;
         default:                      calc_res = rem_fix;
      endcase
   end

   assign a_neg    = op_a_signed(Op) & In_A[W-1];
   assign b_neg    = op_b_signed(Op) & In_B[W-1];
   assign a_mag    = a_neg ? -In_A : In_A;
   assign b_mag    = b_neg ? -In_B : In_B;
   assign div_zero = (In_B == '0);
   assign div_ovf  = ((Op == OP_DIV) || (Op == OP_REM)) &&
                     (In_A == OVF_DIVIDEND) && (In_B == OVF_DIVISOR);

`ifdef MULDIV_FAST_MUL_EN
   logic signed [W2-1:0] fa_x, fb_x, fast_prod;
   assign fa_x      = W2'($signed({op_a_signed(Op) & In_A[W-1], In_A}));
   assign fb_x      = W2'($signed({op_b_signed(Op) & In_B[W-1], In_B}));
   assign fast_prod = fa_x * fb_x;
`endif

   // Next-state and datapath load decisions
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      p_nxt       = p_q;
      m_nxt       = m_q;
      op_nxt      = op_q;
      neg_lo_nxt  = neg_lo_q;
      neg_rem_nxt = neg_rem_q;
      res_nxt     = Result;

      case (state)
         IDLE: begin
            if (Start) begin
               if (Op[2] && div_zero) begin
                  state_nxt = DONE;
                  res_nxt   = Op[1] ? In_A : DIV0_QUOT;
               end else if (div_ovf) begin
                  state_nxt = DONE;
                  res_nxt   = Op[1] ? OVF_REM : OVF_QUOT;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!Op[2]) begin
                  state_nxt = DONE;
                  res_nxt   = (Op == OP_MUL) ? fast_prod[W-1:0] : fast_prod[W2-1:W];
               end
`endif
               else begin
                  state_nxt   = CALC;
                  cnt_nxt     = '0;
                  op_nxt      = Op;
                  neg_lo_nxt  = a_neg ^ b_neg;
                  neg_rem_nxt = a_neg;
                  m_nxt       = Op[2] ? b_mag : a_mag;
                  p_nxt       = {W'(0), Op[2] ? a_mag : b_mag};
               end
            end
         end
         CALC: begin
            p_nxt   = p_step;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(ITER_CNT - 1)) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
               res_nxt   = calc_res;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (Flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         res_nxt   = Result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         p_q       <= '0;
         m_q       <= '0;
         op_q      <= OP_MUL;
         neg_lo_q  <= 1'b0;
         neg_rem_q <= 1'b0;
         Result    <= '0;
         Ready     <= 1'b1;
         Busy      <= 1'b0;
         Done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         p_q       <= p_nxt;
         m_q       <= m_nxt;
         op_q      <= op_nxt;
         neg_lo_q  <= neg_lo_nxt;
         neg_rem_q <= neg_rem_nxt;
         Result    <= res_nxt;
         Ready     <= (state_nxt == IDLE);
         Busy      <= (state_nxt == CALC);
         Done      <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed vector bench for riscv_muldiv_unit (either MULDIV_FAST_MUL_EN build).
module tb_riscv_muldiv_unit;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int NVEC = 20;

   logic        clk = 1'b0;
   logic        rst_n, Start, Flush;
   logic [2:0]  Op;
   logic [31:0] In_A, In_B;
   logic        Ready, Busy, Done;
   logic [31:0] Result;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;
   vec_t vecs [NVEC];

   riscv_muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .Start(Start), .Flush(Flush), .Op(Op),
      .In_A(In_A), .In_B(In_B), .Ready(Ready), .Busy(Busy), .Done(Done),
      .Result(Result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Caller is at a negedge; returns at the negedge of the Done cycle.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output int busy_cnt);
      Start = 1'b1; Op = op; In_A = a; In_B = b;
      @(posedge clk); #1;
      Start = 1'b0;
      lat = -1; res = '0; busy_cnt = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (Busy) busy_cnt++;
         if (Done) begin
            lat = c;
            res = Result;
            break;
         end
      end
   endtask

   initial begin
      int lat, bc, dcount;
      logic [31:0] res, prev;

      vecs[0]  = '{OP_MUL,    32'd7,          32'd6,          32'd42,         MUL_LAT};
      vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
      vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
      vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
      vecs[4]  = '{OP_MUL,    32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFF1, MUL_LAT};
      vecs[5]  = '{OP_MULH,   32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, MUL_LAT};
      vecs[6]  = '{OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, MUL_LAT};
      vecs[7]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33};
      vecs[8]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33};
      vecs[9]  = '{OP_DIVU,   32'd100,        32'd7,          32'd14,         33};
      vecs[10] = '{OP_REMU,   32'd100,        32'd7,          32'd2,          33};
      vecs[11] = '{OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      vecs[12] = '{OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,          33};
      vecs[13] = '{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          33};
      vecs[14] = '{OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
      vecs[15] = '{OP_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF, 1};
      vecs[16] = '{OP_REM,    32'd5,          32'd0,          32'd5,          1};
      vecs[17] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[18] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1};
      vecs[19] = '{OP_DIVU,   32'd100,        32'd7,          32'd14,         33};

      rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; Op = '0; In_A = '0; In_B = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_ready",  32'(Ready),  32'd1);
      chk("reset_busy",   32'(Busy),   32'd0);
      chk("reset_done",   32'(Done),   32'd0);
      chk("reset_result", Result,      32'd0);

      // Each vector starts in the first Ready cycle after the previous one
      for (int i = 0; i < NVEC; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, bc);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("vec%0d_result", i), res, vecs[i].res);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].lat - 1));
         @(negedge clk);
         chk($sformatf("vec%0d_ready_after", i), 32'(Ready), 32'd1);
         chk($sformatf("vec%0d_done_pulse", i), 32'(Done), 32'd0);
         chk($sformatf("vec%0d_result_held", i), Result, vecs[i].res);
      end
      prev = vecs[NVEC-1].res;

      // Flush in CALC cycle 10
      Start = 1'b1; Op = OP_DIVU; In_A = 32'd1000; In_B = 32'd3;
      @(posedge clk); #1; Start = 1'b0;
      repeat (10) @(negedge clk);
      Flush = 1'b1;
      @(posedge clk); #1; Flush = 1'b0;
      @(negedge clk);
      chk("flush_ready",  32'(Ready), 32'd1);
      chk("flush_busy",   32'(Busy),  32'd0);
      chk("flush_done",   32'(Done),  32'd0);
      dcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (Done) dcount++;
      end
      chk("flush_no_done", 32'(dcount), 32'd0);
      chk("flush_result",  Result, prev);

      // Start and Flush together in IDLE
      Start = 1'b1; Flush = 1'b1; Op = OP_DIV; In_A = 32'd5; In_B = 32'd0;
      @(posedge clk); #1; Start = 1'b0; Flush = 1'b0;
      @(negedge clk);
      chk("startflush_ready", 32'(Ready), 32'd1);
      chk("startflush_busy",  32'(Busy),  32'd0);
      dcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (Done) dcount++;
      end
      chk("startflush_no_done", 32'(dcount), 32'd0);
      chk("startflush_result",  Result, prev);

      // Start while Busy is ignored
      Start = 1'b1; Op = OP_DIVU; In_A = 32'd200; In_B = 32'd9;
      @(posedge clk); #1; Start = 1'b0;
      dcount = 0; lat = -1; res = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 5) begin
            Start = 1'b1; Op = OP_DIV; In_A = 32'd5; In_B = 32'd0;
         end else begin
            Start = 1'b0;
         end
         if (Done) begin
            dcount++;
            if (lat < 0) begin
               lat = c;
               res = Result;
            end
         end
      end
      Start = 1'b0;
      chk("ignore_start_latency", 32'(lat),    32'd33);
      chk("ignore_start_result",  res,         32'd22);
      chk("ignore_start_dones",   32'(dcount), 32'd1);

      // Reset asserted during CALC
      Start = 1'b1; Op = OP_REMU; In_A = 32'd200; In_B = 32'd9;
      @(posedge clk); #1; Start = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_reset_busy", 32'(Busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midreset_ready",  32'(Ready), 32'd1);
      chk("midreset_busy",   32'(Busy),  32'd0);
      chk("midreset_done",   32'(Done),  32'd0);
      chk("midreset_result", Result,     32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(OP_MULHSU, 32'hFFFF_FFFE, 32'h8000_0000, lat, res, bc);
      chk("post_reset_latency", 32'(lat), 32'(MUL_LAT));
      chk("post_reset_result",  res,      32'hFFFF_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
